// File: rtl/map_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational wall map among N_REQ requesters; owns map selection swaps.
// Latency: ack in cycle T -> rsp_valid/rsp_wall in T+2; one lookup per cycle sustained.
// Backpressure: req held until ack; no acks while a map swap drains/applies; responses cannot be stalled.
module map_lookup_arbiter #(
    parameter int N_REQ    = 4,
    parameter int GRID_MAX = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_coord,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic                 rsp_wall,
    input  logic [1:0]           map_sel_in,
    input  logic                 map_load,
    output logic [7:0]           map_coord,
    output logic [1:0]           map_select,
    input  logic                 map_is_wall,
    output logic                 busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // Stage 1: granted requester and the cell currently presented to the map.
    typedef struct packed {
        logic       vld;
        ptr_t       id;
        logic [7:0] coord;
    } s1_t;

    // Stage 2: one-hot response strobe and the resolved answer.
    typedef struct packed {
        logic [N_REQ-1:0] rsp_vld;
        logic             wall;
    } s2_t;

    state_t     state_q, state_d;
    ptr_t       rr_ptr_q, rr_ptr_d;
    logic [1:0] pend_sel_q, pend_sel_d;
    logic [1:0] map_sel_q, map_sel_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;

    logic       gnt_found;
    ptr_t       gnt_idx;
    logic       grant_en;
    logic [7:0] gnt_coord;
    logic       lookup_wall;
    logic [N_REQ-1:0] one_hot_base;

    assign one_hot_base = {{(N_REQ-1){1'b0}}, 1'b1};

    // Pick the first asserted request at or after the round-robin pointer.
    always_comb begin
        logic [PTR_W:0] sum;
        ptr_t           cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // A map_load in RUN suppresses the grant so nothing new enters before the drain.
    assign grant_en  = (state_q == ST_RUN) && !map_load && gnt_found;
    assign ack       = grant_en ? (one_hot_base << gnt_idx) : '0;
    assign gnt_coord = req_coord[{gnt_idx, 3'b000} +: 8];

    // Cells beyond the grid read as walls regardless of what the map says.
    assign lookup_wall = (int'(s1_q.coord[7:4]) > GRID_MAX) ||
                         (int'(s1_q.coord[3:0]) > GRID_MAX) ||
                         map_is_wall;

    // Next-state for pointer, pipeline and the map-swap FSM.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pend_sel_d = pend_sel_q;
        map_sel_d  = map_sel_q;

        s1_d       = s1_q;
        s1_d.vld   = grant_en;
        if (grant_en) begin
            s1_d.id    = gnt_idx;
            s1_d.coord = gnt_coord;
            rr_ptr_d   = (gnt_idx == ptr_t'(N_REQ-1)) ? '0 : gnt_idx + ptr_t'(1);
        end

        s2_d.rsp_vld = s1_q.vld ? (one_hot_base << s1_q.id) : '0;
        s2_d.wall    = s1_q.vld & lookup_wall;

        case (state_q)
            ST_RUN: begin
                if (map_load) begin
                    pend_sel_d = map_sel_in;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (map_load) begin
                    pend_sel_d = map_sel_in;
                end
                // Swap only once no granted lookup can still see the map.
                if (!s1_q.vld && (s2_q.rsp_vld == '0)) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                map_sel_d = pend_sel_q;
                // A load landing on the swap cycle is queued for another swap.
                if (map_load) begin
                    pend_sel_d = map_sel_in;
                    state_d    = ST_DRAIN;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // All state registers; reset drops any in-flight lookup.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            rr_ptr_q   <= '0;
            pend_sel_q <= 2'd0;
            map_sel_q  <= 2'd0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_sel_q <= pend_sel_d;
            map_sel_q  <= map_sel_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign map_coord  = s1_q.coord;
    assign map_select = map_sel_q;
    assign rsp_valid  = s2_q.rsp_vld;
    assign rsp_wall   = s2_q.wall;
    assign busy       = s1_q.vld | (s2_q.rsp_vld != '0) | (state_q != ST_RUN);

endmodule

// File: tb/tb_map_lookup_arbiter.sv
module tb_map_lookup_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_coord;
    logic [N-1:0]   ack;
    logic [N-1:0]   rsp_valid;
    logic           rsp_wall;
    logic [1:0]     map_sel_in;
    logic           map_load;
    logic [7:0]     map_coord;
    logic [1:0]     map_select;
    logic           map_is_wall;
    logic           busy;

    typedef struct {
        int   due;
        int   id;
        logic wall;
    } exp_t;

    typedef struct {
        int         id;
        logic [1:0] map;
        logic [7:0] coord;
        logic       wall;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[16];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    map_lookup_arbiter #(.N_REQ(N), .GRID_MAX(12)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_coord(req_coord),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_wall(rsp_wall),
        .map_sel_in(map_sel_in), .map_load(map_load),
        .map_coord(map_coord), .map_select(map_select),
        .map_is_wall(map_is_wall), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wall-map model (no bounds knowledge): map1 x<y, map2 odd x, map0/3 nonzero diagonal.
    function automatic logic wall_fn(input logic [1:0] s, input logic [7:0] c);
        logic [3:0] x, y;
        x = c[7:4];
        y = c[3:0];
        case (s)
            2'd1:    return x < y;
            2'd2:    return x[0];
            default: return (x == y) && (x != 4'd0);
        endcase
    endfunction

    assign map_is_wall = wall_fn(map_select, map_coord);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d: bound expired", name, cyc);
    endtask

    // Scoreboard: every cycle either the due response appears or outputs are idle.
    always @(negedge clk) begin
        while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            mon_e = sb_q.pop_front();
            fail_now("rsp_missing");
        end
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.id);
            chk("rsp_wall", 32'(rsp_wall), 32'(mon_e.wall));
        end else begin
            chk("rsp_idle", {27'd0, rsp_valid, rsp_wall}, 32'd0);
        end
    end

    task automatic push_exp(input int id, input logic w);
        exp_t e;
        e.due  = cyc + 2;
        e.id   = id;
        e.wall = w;
        sb_q.push_back(e);
    endtask

    task automatic do_lookup(input int id, input logic [7:0] c, input logic w);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        req_coord[id*8 +: 8] = c;
        req[id] = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                chk("ack_grant", 32'(ack), 32'(1) << id);
                push_exp(id, w);
            end
            n++;
        end
        if (!got) fail_now("ack_timeout");
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    task automatic map_swap(input logic [1:0] s);
        int n;
        n = 0;
        map_sel_in = s;
        map_load   = 1'b1;
        @(posedge clk); #1;
        map_load = 1'b0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("swap_timeout");
        chk("swap_map_select", 32'(map_select), 32'(s));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(4);
        resetn = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cur_map;
        logic       t2_wall [4];

        resetn     = 1'b0;
        req        = '0;
        req_coord  = '0;
        map_load   = 1'b0;
        map_sel_in = 2'd0;
        cur_map    = 2'd0;

        vecs[0]  = '{1, 2'd0, 8'h11, 1'b1};
        vecs[1]  = '{1, 2'd0, 8'h00, 1'b0};
        vecs[2]  = '{2, 2'd0, 8'hD0, 1'b1};
        vecs[3]  = '{3, 2'd0, 8'h0F, 1'b1};
        vecs[4]  = '{0, 2'd0, 8'hC5, 1'b0};
        vecs[5]  = '{0, 2'd0, 8'h5C, 1'b0};
        vecs[6]  = '{2, 2'd0, 8'hCC, 1'b1};
        vecs[7]  = '{3, 2'd0, 8'h26, 1'b0};
        vecs[8]  = '{2, 2'd1, 8'h26, 1'b1};
        vecs[9]  = '{1, 2'd1, 8'h62, 1'b0};
        vecs[10] = '{0, 2'd1, 8'hDD, 1'b1};
        vecs[11] = '{3, 2'd2, 8'h30, 1'b1};
        vecs[12] = '{3, 2'd2, 8'h2D, 1'b1};
        vecs[13] = '{1, 2'd2, 8'h40, 1'b0};
        vecs[14] = '{1, 2'd3, 8'h44, 1'b1};
        vecs[15] = '{1, 2'd3, 8'h45, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_map_coord", 32'(map_coord), 32'd0);
        chk("rst_map_select", 32'(map_select), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single lookups across maps, bounds and map 3 pass-through
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].map != cur_map) begin
                map_swap(vecs[i].map);
                cur_map = vecs[i].map;
            end
            do_lookup(vecs[i].id, vecs[i].coord, vecs[i].wall);
        end

        // All four requesting: strict rotation, one grant per cycle
        do_reset();
        t2_wall   = '{1'b1, 1'b1, 1'b0, 1'b1};
        req_coord = {8'hE1, 8'h12, 8'h22, 8'h11};
        req       = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_order", 32'(ack), 32'(1) << (k % 4));
            push_exp(k % 4, t2_wall[k % 4]);
        end
        @(posedge clk); #1;
        req = '0;

        // map_load with two lookups in flight
        idle(4);
        req_coord = {8'h00, 8'h26, 8'h00, 8'h11};
        req = 4'b0011;
        @(negedge clk);
        chk("t4_ack0", 32'(ack), 32'h1);
        push_exp(0, 1'b1);
        @(posedge clk); #1;
        req = 4'b0010;
        @(negedge clk);
        chk("t4_ack1", 32'(ack), 32'h2);
        push_exp(1, 1'b0);
        @(posedge clk); #1;
        req        = 4'b0100;
        map_sel_in = 2'd1;
        map_load   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_ack_blocked", 32'(ack), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            chk("t4_old_map", 32'(map_select), 32'd0);
            @(posedge clk); #1;
            map_load = 1'b0;
        end
        @(negedge clk);
        chk("t4_ack_after_swap", 32'(ack), 32'h4);
        chk("t4_new_map", 32'(map_select), 32'd1);
        chk("t4_busy_clear", 32'(busy), 32'd0);
        push_exp(2, 1'b1);
        @(posedge clk); #1;
        req = '0;

        // Two loads during drain: latest wins
        idle(4);
        map_swap(2'd0);
        map_sel_in = 2'd2;
        map_load   = 1'b1;
        @(posedge clk); #1;
        map_sel_in = 2'd1;
        @(posedge clk); #1;
        map_load = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (busy && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (busy) fail_now("t5_timeout");
        end
        chk("t5_latest_wins", 32'(map_select), 32'd1);

        // Reset with both stages full
        @(posedge clk); #1;
        req_coord = {8'h00, 8'h00, 8'h33, 8'h00};
        req = 4'b0011;
        @(negedge clk);
        chk("t6_ack0", 32'(ack), 32'h1);
        @(posedge clk); #1;
        req = 4'b0010;
        @(negedge clk);
        chk("t6_ack1", 32'(ack), 32'h2);
        @(posedge clk); #1;
        req    = '0;
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_map_select", 32'(map_select), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(4);
        req = 4'hF;
        @(negedge clk);
        chk("t6_first_grant", 32'(ack), 32'h1);
        push_exp(0, 1'b0);
        @(posedge clk); #1;
        req = '0;

        idle(6);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
